// File: rtl/i2c_pkg.sv
// Shared types for the I2C access arbiter: sequencer states and response status codes.
package i2c_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DRAIN,
        ARB_RESP
    } i2c_arb_state_t;

    localparam logic [1:0] I2C_ST_OK      = 2'b00;
    localparam logic [1:0] I2C_ST_INVALID = 2'b01;
    localparam logic [1:0] I2C_ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from last_grant+1.
// Zero latency; no backpressure, the caller decides when to consume the pick.
module rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GRANT_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]     req,
    input  logic [GRANT_WIDTH-1:0] last_grant,
    output logic [GRANT_WIDTH-1:0] win_idx,
    output logic                   win_valid
);

    int idx;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        idx       = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (req[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx[GRANT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/i2c_access_arbiter.sv
// Shares one i2c_controller access port among NUM_REQ requesters, round-robin.
// Issue one cycle after arbitration, ack one cycle after complete; holds off while m_busy.
module i2c_access_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BYTES     = 4,
    parameter int BYTE_WIDTH     = $clog2(DATA_BYTES),
    parameter int DATA_WIDTH     = DATA_BYTES * 8,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int GRANT_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*8-1:0]          req_dev_id,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*BYTE_WIDTH-1:0] req_address_byte,
    input  logic [NUM_REQ*BYTE_WIDTH-1:0] req_data_byte,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_write_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rsp_read_data,
    output logic [1:0]                    rsp_status,
    output logic [GRANT_WIDTH-1:0]        grant,
    output logic                          grant_valid,
    output logic                          m_access_request,
    output logic [7:0]                    m_dev_id,
    output logic [DATA_WIDTH-1:0]         m_address,
    output logic [BYTE_WIDTH-1:0]         m_address_byte,
    output logic [BYTE_WIDTH-1:0]         m_data_byte,
    output logic [DATA_WIDTH-1:0]         m_write_data,
    input  logic [DATA_WIDTH-1:0]         m_read_data,
    input  logic                          m_access_complete,
    input  logic                          m_invalid_access,
    input  logic                          m_busy
);

    localparam int                     TIMER_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST  = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    i2c_arb_state_t         state, state_next;
    logic [GRANT_WIDTH-1:0] last_grant;
    logic [GRANT_WIDTH-1:0] win_idx;
    logic                   win_valid;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   timer_done;

    logic [7:0]            dev_arr   [NUM_REQ];
    logic [DATA_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [BYTE_WIDTH-1:0] abyte_arr [NUM_REQ];
    logic [BYTE_WIDTH-1:0] dbyte_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign dev_arr[i]   = req_dev_id[i*8 +: 8];
        assign addr_arr[i]  = req_address[i*DATA_WIDTH +: DATA_WIDTH];
        assign abyte_arr[i] = req_address_byte[i*BYTE_WIDTH +: BYTE_WIDTH];
        assign dbyte_arr[i] = req_data_byte[i*BYTE_WIDTH +: BYTE_WIDTH];
        assign wdata_arr[i] = req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .GRANT_WIDTH (GRANT_WIDTH)
    ) u_rr_arbiter (
        .req        (req),
        .last_grant (last_grant),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    assign timer_done = (timer == TIMER_LAST);

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:  if (win_valid && !m_busy) state_next = ARB_ISSUE;
            ARB_ISSUE: state_next = ARB_WAIT;
            ARB_WAIT: begin
                if (m_access_complete) state_next = ARB_RESP;
                else if (timer_done)   state_next = ARB_DRAIN;
            end
            ARB_DRAIN: if (!m_busy) state_next = ARB_RESP;
            ARB_RESP:  state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_next;
    end

    // Outputs are registered from state_next so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack              <= '0;
            rsp_read_data    <= '0;
            rsp_status       <= I2C_ST_OK;
            grant            <= '0;
            grant_valid      <= 1'b0;
            m_access_request <= 1'b0;
            m_dev_id         <= '0;
            m_address        <= '0;
            m_address_byte   <= '0;
            m_data_byte      <= '0;
            m_write_data     <= '0;
            last_grant       <= GRANT_WIDTH'(NUM_REQ - 1);
            timer            <= '0;
        end else begin
            m_access_request <= (state_next == ARB_ISSUE);
            grant_valid      <= (state_next != ARB_IDLE);
            ack              <= '0;
            if (state_next == ARB_RESP) ack[grant] <= 1'b1;

            case (state)
                ARB_IDLE: begin
                    if (state_next == ARB_ISSUE) begin
                        grant          <= win_idx;
                        m_dev_id       <= dev_arr[win_idx];
                        m_address      <= addr_arr[win_idx];
                        m_address_byte <= abyte_arr[win_idx];
                        m_data_byte    <= dbyte_arr[win_idx];
                        m_write_data   <= wdata_arr[win_idx];
                    end
                end
                ARB_ISSUE: timer <= '0;
                ARB_WAIT: begin
                    if (m_access_complete) begin
                        rsp_read_data <= m_read_data;
                        rsp_status    <= m_invalid_access ? I2C_ST_INVALID : I2C_ST_OK;
                    end else if (timer_done) begin
                        rsp_read_data <= '0;
                        rsp_status    <= I2C_ST_TIMEOUT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ARB_RESP: last_grant <= grant;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_access_arbiter.sv
// Directed bench for i2c_access_arbiter; a second instance with a short timeout covers the timeout path.
module tb_i2c_access_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [31:0]  req_dev_id;
    logic [127:0] req_address;
    logic [7:0]   req_address_byte;
    logic [7:0]   req_data_byte;
    logic [127:0] req_write_data;
    logic [31:0]  m_read_data;
    logic         m_access_complete;
    logic         m_invalid_access;
    logic         m_busy;

    logic [3:0]  ack, t_ack;
    logic [31:0] rsp_read_data, t_rsp_read_data;
    logic [1:0]  rsp_status, t_rsp_status;
    logic [1:0]  grant, t_grant;
    logic        grant_valid, t_grant_valid;
    logic        m_access_request, t_m_access_request;
    logic [7:0]  m_dev_id, t_m_dev_id;
    logic [31:0] m_address, t_m_address;
    logic [1:0]  m_address_byte, t_m_address_byte;
    logic [1:0]  m_data_byte, t_m_data_byte;
    logic [31:0] m_write_data, t_m_write_data;

    int n_assert = 0;
    int n_fail   = 0;
    int acc_req;
    int acc_ack;

    logic [7:0]  dev_tab  [4];
    logic [31:0] addr_tab [4];
    logic [31:0] wd_tab   [4];

    always #5 clk = ~clk;

    i2c_access_arbiter #(.NUM_REQ(4), .DATA_BYTES(4), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .reset(reset), .req(req), .req_dev_id(req_dev_id),
        .req_address(req_address), .req_address_byte(req_address_byte),
        .req_data_byte(req_data_byte), .req_write_data(req_write_data),
        .ack(ack), .rsp_read_data(rsp_read_data), .rsp_status(rsp_status),
        .grant(grant), .grant_valid(grant_valid), .m_access_request(m_access_request),
        .m_dev_id(m_dev_id), .m_address(m_address), .m_address_byte(m_address_byte),
        .m_data_byte(m_data_byte), .m_write_data(m_write_data), .m_read_data(m_read_data),
        .m_access_complete(m_access_complete), .m_invalid_access(m_invalid_access),
        .m_busy(m_busy)
    );

    i2c_access_arbiter #(.NUM_REQ(4), .DATA_BYTES(4), .TIMEOUT_CYCLES(64)) dut_t (
        .clk(clk), .reset(reset), .req(req), .req_dev_id(req_dev_id),
        .req_address(req_address), .req_address_byte(req_address_byte),
        .req_data_byte(req_data_byte), .req_write_data(req_write_data),
        .ack(t_ack), .rsp_read_data(t_rsp_read_data), .rsp_status(t_rsp_status),
        .grant(t_grant), .grant_valid(t_grant_valid), .m_access_request(t_m_access_request),
        .m_dev_id(t_m_dev_id), .m_address(t_m_address), .m_address_byte(t_m_address_byte),
        .m_data_byte(t_m_data_byte), .m_write_data(t_m_write_data), .m_read_data(m_read_data),
        .m_access_complete(m_access_complete), .m_invalid_access(m_invalid_access),
        .m_busy(m_busy)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_ack"},         64'(ack), 64'h0);
        check({pfx, "_rdata"},       64'(rsp_read_data), 64'h0);
        check({pfx, "_status"},      64'(rsp_status), 64'h0);
        check({pfx, "_grant"},       64'(grant), 64'h0);
        check({pfx, "_grant_valid"}, 64'(grant_valid), 64'h0);
        check({pfx, "_access_req"},  64'(m_access_request), 64'h0);
        check({pfx, "_dev_id"},      64'(m_dev_id), 64'h0);
        check({pfx, "_address"},     64'(m_address), 64'h0);
        check({pfx, "_abyte"},       64'(m_address_byte), 64'h0);
        check({pfx, "_dbyte"},       64'(m_data_byte), 64'h0);
        check({pfx, "_wdata"},       64'(m_write_data), 64'h0);
        check({pfx, "_t_ack"},       64'(t_ack), 64'h0);
        check({pfx, "_t_grant_vld"}, 64'(t_grant_valid), 64'h0);
    endtask

    initial begin
        dev_tab  = '{8'h30, 8'h51, 8'hA0, 8'h36};
        addr_tab = '{32'h0000_0100, 32'h0000_0204, 32'h0000_0010, 32'h0000_0308};
        wd_tab   = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'h4444_4444};
        for (int i = 0; i < 4; i++) begin
            req_dev_id[i*8 +: 8]      = dev_tab[i];
            req_address[i*32 +: 32]   = addr_tab[i];
            req_write_data[i*32 +: 32] = wd_tab[i];
        end
        req_address_byte  = 8'b00_00_00_01;
        req_data_byte     = 8'b11_11_11_11;
        req_address_byte[5:4] = 2'd0;
        req_data_byte[5:4]    = 2'd3;
        reset             = 1'b1;
        req               = 4'b0000;
        m_read_data       = 32'h0;
        m_access_complete = 1'b0;
        m_invalid_access  = 1'b0;
        m_busy            = 1'b0;

        // Reset state
        step(2);
        check_reset_vals("rst0");

        // Single write from requester 2, completed after 500 cycles
        req   = 4'b0100;
        reset = 1'b0;
        step(1);
        check("t1_issue",  64'(m_access_request), 64'h1);
        check("t1_grant",  64'(grant), 64'h2);
        check("t1_gvld",   64'(grant_valid), 64'h1);
        check("t1_dev",    64'(m_dev_id), 64'hA0);
        check("t1_addr",   64'(m_address), 64'h10);
        check("t1_wdata",  64'(m_write_data), 64'hDEADBEEF);
        check("t1_abyte",  64'(m_address_byte), 64'h0);
        check("t1_dbyte",  64'(m_data_byte), 64'h3);
        acc_req = 0;
        acc_ack = 0;
        for (int i = 0; i < 499; i++) begin
            step(1);
            if (m_access_request) acc_req++;
            if (ack != 4'b0000)   acc_ack++;
        end
        check("t1_extra_issue", 64'(acc_req), 64'h0);
        check("t1_early_ack",   64'(acc_ack), 64'h0);
        check("t1_fields_hold", 64'(m_write_data), 64'hDEADBEEF);
        m_access_complete = 1'b1;
        step(1);
        m_access_complete = 1'b0;
        check("t1_ack",    64'(ack), 64'h4);
        check("t1_status", 64'(rsp_status), 64'h0);
        req = 4'b0000;
        step(1);
        check("t1_ack_pulse", 64'(ack), 64'h0);
        check("t1_gvld_off",  64'(grant_valid), 64'h0);

        // All four requesting from reset: round-robin 0,1,2,3,0
        reset = 1'b1;
        req   = 4'b1111;
        step(2);
        reset = 1'b0;
        step(1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_issue%0d", k), 64'(m_access_request), 64'h1);
            check($sformatf("t2_grant%0d", k), 64'(grant), 64'(k % 4));
            check($sformatf("t2_dev%0d", k),   64'(m_dev_id), 64'(dev_tab[k % 4]));
            step(20);
            m_access_complete = 1'b1;
            step(1);
            m_access_complete = 1'b0;
            check($sformatf("t2_ack%0d", k),    64'(ack), 64'(4'b0001 << (k % 4)));
            check($sformatf("t2_status%0d", k), 64'(rsp_status), 64'h0);
            step(2);
        end

        // Read returning data with invalid_access
        reset = 1'b1;
        req   = 4'b0010;
        step(2);
        reset = 1'b0;
        step(1);
        check("t3_issue", 64'(m_access_request), 64'h1);
        check("t3_dev",   64'(m_dev_id), 64'h51);
        step(5);
        m_read_data       = 32'h1234_5678;
        m_invalid_access  = 1'b1;
        m_access_complete = 1'b1;
        step(1);
        m_access_complete = 1'b0;
        m_invalid_access  = 1'b0;
        m_read_data       = 32'hCAFE_F00D;
        check("t3_ack",      64'(ack), 64'h2);
        check("t3_rdata",    64'(rsp_read_data), 64'h12345678);
        check("t3_status",   64'(rsp_status), 64'h1);
        check("t3_t_rdata",  64'(t_rsp_read_data), 64'h12345678);

        // Timeout on the short-timeout instance; busy held 100 cycles, late complete in DRAIN
        req = 4'b0001;
        step(2);
        check("t4_issue", 64'(t_m_access_request), 64'h1);
        check("t4_grant", 64'(t_grant), 64'h0);
        m_busy  = 1'b1;
        acc_ack = 0;
        for (int i = 1; i <= 100; i++) begin
            step(1);
            if (t_ack != 4'b0000) acc_ack++;
            if (i == 80) m_access_complete = 1'b1;
            if (i == 81) m_access_complete = 1'b0;
        end
        check("t4_no_early_ack", 64'(acc_ack), 64'h0);
        check("t4_gvld_drain",   64'(t_grant_valid), 64'h1);
        m_busy = 1'b0;
        step(1);
        check("t4_ack",    64'(t_ack), 64'h1);
        check("t4_status", 64'(t_rsp_status), 64'h2);
        check("t4_rdata",  64'(t_rsp_read_data), 64'h0);
        req = 4'b0000;
        acc_ack = 0;
        m_access_complete = 1'b1;
        step(1);
        if (t_ack != 4'b0000) acc_ack++;
        m_access_complete = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (t_ack != 4'b0000) acc_ack++;
        end
        check("t4_no_second_ack", 64'(acc_ack), 64'h0);
        check("t4_idle_gvld",     64'(t_grant_valid), 64'h0);

        // Controller busy holds off the issue
        reset  = 1'b1;
        m_busy = 1'b1;
        req    = 4'b0010;
        step(2);
        reset   = 1'b0;
        acc_req = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (m_access_request) acc_req++;
        end
        check("t5_held_off", 64'(acc_req), 64'h0);
        m_busy = 1'b0;
        step(1);
        check("t5_issue", 64'(m_access_request), 64'h1);
        check("t5_grant", 64'(grant), 64'h1);

        // Reset in WAIT abandons the transaction; req[3] only wins when alone
        step(3);
        req   = 4'b1010;
        reset = 1'b1;
        step(1);
        check_reset_vals("t6_rst");
        acc_ack = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (ack != 4'b0000 || t_ack != 4'b0000) acc_ack++;
        end
        check("t6_no_ack", 64'(acc_ack), 64'h0);
        reset = 1'b0;
        step(1);
        check("t6_issue_a", 64'(m_access_request), 64'h1);
        check("t6_grant_a", 64'(grant), 64'h1);
        reset = 1'b1;
        req   = 4'b1000;
        step(2);
        reset = 1'b0;
        step(1);
        check("t6_issue_b", 64'(m_access_request), 64'h1);
        check("t6_grant_b", 64'(grant), 64'h3);
        check("t6_dev_b",   64'(m_dev_id), 64'h36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_access_arbiter.md
# i2c_access_arbiter

Round-robin arbiter and sequencer that shares one `i2c_controller` access port between `NUM_REQ` independent requesters, such as a sensor poller, a config loader and a CPU bridge. It selects one pending request and latches its fields. It then issues a single-cycle `access_request` to the controller, waits for `access_complete` or a timeout, and returns read data plus a status code to the granted requester. It sits directly between the requester logic and `i2c_controller`.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2
- `DATA_BYTES`, 4: must match controller
- `BYTE_WIDTH`, `$clog2(DATA_BYTES)`
- `DATA_WIDTH`, `DATA_BYTES*8`
- `TIMEOUT_CYCLES`, 65536: `clk` cycles allowed from issue to `access_complete`
- `GRANT_WIDTH`, `$clog2(NUM_REQ)`

Ports:
- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `req` in NUM_REQ: per-requester level request, held until matching `ack` bit
- `req_dev_id` in NUM_REQ*8: per-requester device byte; bit0 is R/W_n
- `req_address` in NUM_REQ*DATA_WIDTH: register address
- `req_address_byte` in NUM_REQ*BYTE_WIDTH
- `req_data_byte` in NUM_REQ*BYTE_WIDTH
- `req_write_data` in NUM_REQ*DATA_WIDTH
- `ack` out NUM_REQ: one-cycle completion pulse; one-hot or zero
- `rsp_read_data` out DATA_WIDTH: valid when any `ack` bit is high
- `rsp_status` out 2: 00 ok, 01 invalid_access, 10 timeout; valid with `ack`
- `grant` out GRANT_WIDTH: index of the current owner
- `grant_valid` out 1: high from issue through the response
- `m_access_request` out 1: to controller
- `m_dev_id` out 8
- `m_address` out DATA_WIDTH
- `m_address_byte` out BYTE_WIDTH
- `m_data_byte` out BYTE_WIDTH
- `m_write_data` out DATA_WIDTH
- `m_read_data` in DATA_WIDTH: from controller
- `m_access_complete` in 1: from controller
- `m_invalid_access` in 1: from controller
- `m_busy` in 1: from controller

## Operation
- FSM states: IDLE, ISSUE, WAIT, DRAIN, RESP.
- IDLE:
  - Condition to arbitrate: `|req && !m_busy`.
  - Pick the first set `req` bit searching upward from `last_grant+1` modulo NUM_REQ.
  - Latch the winner's fields into the `m_*` registers and `grant`, then go to ISSUE.
- ISSUE:
  - `m_access_request` = 1 for exactly this one cycle.
  - Clear the timer and go to WAIT.
- WAIT:
  - On `m_access_complete`: capture `m_read_data`; status = `m_invalid_access` ? 01 : 00; go to RESP.
  - Otherwise, when the timer reaches TIMEOUT_CYCLES-1: status = 10, `rsp_read_data` = 0, go to DRAIN.
  - Otherwise, increment the timer.
- DRAIN:
  - Stay here while `m_busy` is high.
  - Ignore a late `m_access_complete` (no second `ack`).
  - Go to RESP when `m_busy` is low.
- RESP:
  - `ack[grant]` = 1 for one cycle.
  - `last_grant` <= `grant`.
  - Go to IDLE.
- `m_*` fields stay stable from ISSUE until the next arbitration. `grant_valid` = state ∈ {ISSUE, WAIT, DRAIN, RESP}.
- Boundary and error cases:
  - A requester that drops `req` before its `ack`: the transaction still completes and `ack` still pulses.
  - `req` re-asserted on the cycle after `ack`: eligible, but ranks after the other pending requesters.
  - `m_access_complete` arriving in IDLE or ISSUE: ignored.
  - Timer width is `$clog2(TIMEOUT_CYCLES)`; it never wraps because it stops at the limit.

## Timing
- Reset values:
  - state IDLE
  - `ack` 0
  - `rsp_read_data` 0
  - `rsp_status` 00
  - `grant` 0
  - `grant_valid` 0
  - `m_access_request` 0
  - all `m_*` fields 0
  - `last_grant` NUM_REQ-1, so requester 0 wins first after reset
- Reset mid-transaction: abandon with no `ack`; the controller shares `reset`.
- All outputs are registered.
- `req` sampled in IDLE at cycle N → `m_access_request` high at N+1.
- `m_access_complete` seen at cycle M → `ack` and `rsp_*` valid at M+1.
- Next arbitration is no earlier than M+2; minimum gap between issues is 4 cycles plus controller latency.
- Timeout: `ack` with status 10 arrives no earlier than TIMEOUT_CYCLES+2 cycles after ISSUE.

## Structure
- Shared package `i2c_pkg`:
  - `i2c_arb_state_t` enum
  - status constants `I2C_ST_OK`, `I2C_ST_INVALID`, `I2C_ST_TIMEOUT`
- Sub-module `rr_arbiter`:
  - Combinational round-robin priority pick over `req`, with inputs `req` and `last_grant`.
  - Outputs `win_idx` and `win_valid`.
  - Reusable for other shared low-speed controllers.

## Test plan
- Single requester: `req[2]` write, dev_id 0xA0, address 0x10, data 0xDEADBEEF; controller model completes after 500 cycles → `m_access_request` pulses once with those fields, and `ack` = 4'b0100 with status 00 one cycle after complete.
- All four `req` high from reset, model completes each request after 20 cycles → grant order 0,1,2,3,0; each `ack` is one-hot and in that order.
- Read: model returns `m_read_data` 0x12345678 with `m_invalid_access` = 1 → `rsp_read_data` 0x12345678, `rsp_status` 01.
- Timeout with TIMEOUT_CYCLES=64: model never completes and holds `m_busy` for 100 cycles → no `ack` until `m_busy` falls, then `ack` with status 10 and data 0. A late `m_access_complete` produces no extra `ack`.
- `m_busy` high while `req[1]` asserted → no `m_access_request` until `m_busy` low, then issue on the next cycle.
- Reset asserted during WAIT → all outputs return to reset values and no `ack` pulses. `req[3]` held through reset is served first afterwards only if `req[0..2]` are low.
